// File: rtl/winner_vote_acc.sv
// winner_vote_acc: per-class vote accumulator behind the 10-input max comparator.
// Qualified comparator wins are counted per class over a sample window. A
// 10-cycle sequential scan then picks the class with the most votes. Ties go to
// the lower class, and the result is published with a one-cycle done pulse.
module winner_vote_acc #(
  parameter int unsigned p_width     = 19,
  parameter int unsigned p_cnt_width = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_sample_start,
  input  logic                   i_sample_end,
  input  logic                   i_valid,
  input  logic [10:1]            i_index,
  input  logic [p_width-1:0]     i_result,
  input  logic [p_width-1:0]     i_threshold,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [3:0]             o_class,
  output logic [10:1]            o_class_onehot,
  output logic [p_cnt_width-1:0] o_votes,
  output logic                   o_no_decision
);

  localparam int unsigned lp_n_class   = 10;
  localparam logic [3:0]  lp_scan_last = 4'd9;
  localparam logic [3:0]  lp_no_class  = 4'hF;
  localparam logic [p_cnt_width-1:0] lp_cnt_one = {{(p_cnt_width-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACC     = 2'd1,
    S_RESOLVE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                 r_state;
  logic [p_cnt_width-1:0] r_cnt [lp_n_class];
  logic [3:0]             r_scan_idx;
  logic [3:0]             r_max_idx;
  logic [p_cnt_width-1:0] r_max;

  logic                   w_onehot;
  logic                   w_vote;
  logic [3:0]             w_vote_cls;
  logic                   w_vote_sat;
  logic [p_cnt_width-1:0] w_scan_cnt;
  logic                   w_scan_gt;
  logic [p_cnt_width-1:0] w_new_max;
  logic [3:0]             w_new_idx;

  // Vote qualification: exactly one winner bit and result at/above threshold.
  always_comb begin
    w_vote_cls = 4'd0;
    for (int k = 0; k < int'(lp_n_class); k++) begin
      if (i_index[k+1]) w_vote_cls = 4'(k);
    end
    w_onehot   = (i_index != 10'd0) && ((i_index & (i_index - 10'd1)) == 10'd0);
    w_vote     = i_valid && (i_result >= i_threshold) && w_onehot;
    w_vote_sat = (r_cnt[w_vote_cls] == {p_cnt_width{1'b1}});
  end

  // One scan step: strict greater-than keeps the lower class on ties.
  always_comb begin
    w_scan_cnt = r_cnt[r_scan_idx];
    w_scan_gt  = (w_scan_cnt > r_max);
    w_new_max  = w_scan_gt ? w_scan_cnt : r_max;
    w_new_idx  = w_scan_gt ? r_scan_idx : r_max_idx;
  end

  // Window FSM, counters, scan registers and registered decision outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      for (int k = 0; k < int'(lp_n_class); k++) r_cnt[k] <= '0;
      r_scan_idx     <= 4'd0;
      r_max_idx      <= 4'd0;
      r_max          <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_class        <= 4'd0;
      o_class_onehot <= 10'd0;
      o_votes        <= '0;
      o_no_decision  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_sample_start) begin
            for (int k = 0; k < int'(lp_n_class); k++) r_cnt[k] <= '0;
            r_state <= S_ACC;
            o_busy  <= 1'b1;
          end
        end

        S_ACC: begin
          if (i_sample_end) begin
            // The vote arriving with end still belongs to this window.
            if (w_vote && !w_vote_sat) r_cnt[w_vote_cls] <= r_cnt[w_vote_cls] + lp_cnt_one;
            r_scan_idx <= 4'd0;
            r_max_idx  <= 4'd0;
            r_max      <= '0;
            r_state    <= S_RESOLVE;
          end else if (i_sample_start) begin
            // Restart discards the old window and any vote in this cycle.
            for (int k = 0; k < int'(lp_n_class); k++) r_cnt[k] <= '0;
          end else if (w_vote && !w_vote_sat) begin
            r_cnt[w_vote_cls] <= r_cnt[w_vote_cls] + lp_cnt_one;
          end
        end

        S_RESOLVE: begin
          r_max     <= w_new_max;
          r_max_idx <= w_new_idx;
          if (r_scan_idx == lp_scan_last) begin
            r_state <= S_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            if (w_new_max == '0) begin
              o_no_decision  <= 1'b1;
              o_class        <= lp_no_class;
              o_class_onehot <= 10'd0;
              o_votes        <= '0;
            end else begin
              o_no_decision  <= 1'b0;
              o_class        <= w_new_idx;
              o_class_onehot <= 10'(10'd1 << w_new_idx);
              o_votes        <= w_new_max;
            end
          end else begin
            r_scan_idx <= r_scan_idx + 4'd1;
          end
        end

        S_DONE: begin
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_winner_vote_acc.sv
// tb_winner_vote_acc: table-driven windows, hand-written corner sequences and
// randomized windows checked against a count-then-argmax reference model.
// Two instances run side by side: 8-bit counters and 4-bit (saturating) counters.
module tb_winner_vote_acc;

  localparam int unsigned W = 19;

  logic          clk = 1'b0;
  logic          rst, start, send, valid;
  logic [10:1]   idx;
  logic [W-1:0]  res, thr;

  logic          busy_a, done_a, nd_a;
  logic [3:0]    class_a;
  logic [10:1]   oh_a;
  logic [7:0]    votes_a;
  logic          busy_b, done_b, nd_b;
  logic [3:0]    class_b;
  logic [10:1]   oh_b;
  logic [3:0]    votes_b;

  int n_tests = 0;
  int n_fail  = 0;
  int m_raw[10];
  bit m_acc = 0;

  always #5 clk = ~clk;

  winner_vote_acc #(.p_width(W), .p_cnt_width(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_sample_start(start), .i_sample_end(send),
    .i_valid(valid), .i_index(idx), .i_result(res), .i_threshold(thr),
    .o_busy(busy_a), .o_done(done_a), .o_class(class_a), .o_class_onehot(oh_a),
    .o_votes(votes_a), .o_no_decision(nd_a));

  winner_vote_acc #(.p_width(W), .p_cnt_width(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_sample_start(start), .i_sample_end(send),
    .i_valid(valid), .i_index(idx), .i_result(res), .i_threshold(thr),
    .o_busy(busy_b), .o_done(done_b), .o_class(class_b), .o_class_onehot(oh_b),
    .o_votes(votes_b), .o_no_decision(nd_b));

  typedef struct {
    int a_cls; int a_n; int b_cls; int b_n; int res; int thr;
    int cls8; int v8; int cls4; int v4; int nd;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [10:1] cls_oh(input int c);
    logic [10:1] x;
    x = 10'(10'd1 << c);
    return x;
  endfunction

  // Reference vote rule: returns class 0..9 for a counted vote, else -1.
  function automatic int vote_class(input logic v, input logic [10:1] ix,
                                    input logic [W-1:0] r, input logic [W-1:0] t);
    int ones;
    int c;
    ones = 0;
    c = -1;
    for (int k = 1; k <= 10; k++) begin
      if (ix[k]) begin
        ones++;
        c = k - 1;
      end
    end
    if (v && (r >= t) && ones == 1) return c;
    return -1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 10; k++) m_raw[k] = 0;
  endtask

  // One input cycle during IDLE/ACC, with the reference model following along.
  task automatic cyc(input logic s, input logic e, input logic v, input logic [10:1] ix,
                     input logic [W-1:0] r, input logic [W-1:0] t);
    int c;
    start = s; send = e; valid = v; idx = ix; res = r; thr = t;
    c = vote_class(v, ix, r, t);
    if (m_acc) begin
      if (e) begin
        if (c >= 0) m_raw[c]++;
        m_acc = 0;
      end else if (s) begin
        model_clear();
      end else if (c >= 0) begin
        m_raw[c]++;
      end
    end else if (s) begin
      model_clear();
      m_acc = 1;
    end
    tick();
    start = 0; send = 0; valid = 0; idx = '0; res = '0; thr = '0;
  endtask

  task automatic model_expect(input int w, output int cls, output int votes, output int nd);
    int sat;
    int best;
    int v;
    sat = (1 << w) - 1;
    best = 0;
    cls = 0;
    for (int c = 0; c < 10; c++) begin
      v = (m_raw[c] > sat) ? sat : m_raw[c];
      if (v > best) begin
        best = v;
        cls = c;
      end
    end
    nd = (best == 0) ? 1 : 0;
    if (nd != 0) cls = 15;
    votes = best;
  endtask

  // Called right after the edge that sampled i_sample_end. Junk on the
  // control inputs during the scan must be ignored.
  task automatic resolve_check(input string name, input int cls8, input int v8,
                               input int cls4, input int v4, input int nd, input bit junk);
    logic early;
    logic lost_busy;
    early = 0;
    lost_busy = 0;
    for (int i = 1; i <= 10; i++) begin
      if (junk) begin
        start = 1'($urandom); send = 1'($urandom); valid = 1'($urandom);
        idx = 10'($urandom); res = W'($urandom); thr = '0;
      end
      if (i == 10) begin
        tick();
      end else begin
        tick();
        if (done_a || done_b) early = 1;
        if (!busy_a || !busy_b) lost_busy = 1;
      end
    end
    start = 0; send = 0; valid = 0; idx = '0; res = '0; thr = '0;
    check({name, "/early_done"}, 32'(early), 32'd0);
    check({name, "/busy_in_scan"}, 32'(lost_busy), 32'd0);
    check({name, "/done_a"}, 32'(done_a), 32'd1);
    check({name, "/done_b"}, 32'(done_b), 32'd1);
    check({name, "/busy_at_done"}, 32'(busy_a), 32'd0);
    check({name, "/class8"}, 32'(class_a), 32'(cls8));
    check({name, "/votes8"}, 32'(votes_a), 32'(v8));
    check({name, "/onehot8"}, 32'(oh_a), (nd != 0) ? 32'd0 : 32'(cls_oh(cls8)));
    check({name, "/nodec8"}, 32'(nd_a), 32'(nd));
    check({name, "/class4"}, 32'(class_b), 32'(cls4));
    check({name, "/votes4"}, 32'(votes_b), 32'(v4));
    check({name, "/nodec4"}, 32'(nd_b), 32'(nd));
    tick();
    check({name, "/done_drop"}, 32'(done_a), 32'd0);
    check({name, "/class_hold"}, 32'(class_a), 32'(cls8));
  endtask

  task automatic model_resolve(input string name, input bit junk);
    int c8, v8, n8, c4, v4, n4;
    model_expect(8, c8, v8, n8);
    model_expect(4, c4, v4, n4);
    resolve_check(name, c8, v8, c4, v4, n8, junk);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "/busy"},  32'(busy_a | busy_b), 32'd0);
    check({name, "/done"},  32'(done_a | done_b), 32'd0);
    check({name, "/class"}, 32'(class_a), 32'd0);
    check({name, "/onehot"}, 32'(oh_a), 32'd0);
    check({name, "/votes"}, 32'(votes_a), 32'd0);
    check({name, "/nodec"}, 32'(nd_a), 32'd0);
  endtask

  initial begin
    logic seen;
    int nc;
    logic [10:1] rix;
    int sel;

    tbl[0] = '{a_cls:2, a_n:5,  b_cls:6, b_n:2,  res:100, thr:50,  cls8:2,  v8:5,  cls4:2,  v4:5,  nd:0};
    tbl[1] = '{a_cls:1, a_n:3,  b_cls:8, b_n:3,  res:100, thr:50,  cls8:1,  v8:3,  cls4:1,  v4:3,  nd:0};
    tbl[2] = '{a_cls:4, a_n:3,  b_cls:5, b_n:2,  res:49,  thr:50,  cls8:15, v8:0,  cls4:15, v4:0,  nd:1};
    tbl[3] = '{a_cls:9, a_n:20, b_cls:0, b_n:0,  res:7,   thr:7,   cls8:9,  v8:20, cls4:9,  v4:15, nd:0};
    tbl[4] = '{a_cls:0, a_n:16, b_cls:9, b_n:20, res:300, thr:299, cls8:9,  v8:20, cls4:0,  v4:15, nd:0};
    tbl[5] = '{a_cls:0, a_n:2,  b_cls:3, b_n:2,  res:0,   thr:0,   cls8:0,  v8:2,  cls4:0,  v4:2,  nd:0};

    rst = 1; start = 0; send = 0; valid = 0; idx = '0; res = '0; thr = '0;
    model_clear();
    tick();
    tick();
    check_reset_state("reset");
    rst = 0;

    // IDLE ignores votes and sample_end.
    cyc(0, 1, 1, cls_oh(3), 5, 1);
    cyc(0, 0, 1, cls_oh(3), 5, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_a || busy_a) seen = 1;
    end
    check("idle_ignore", 32'(seen), 32'd0);

    // Table-driven windows.
    foreach (tbl[i]) begin
      cyc(1, 0, 0, '0, 0, 0);
      check($sformatf("tbl%0d/busy_acc", i), 32'(busy_a), 32'd1);
      for (int n = 0; n < tbl[i].a_n; n++) cyc(0, 0, 1, cls_oh(tbl[i].a_cls), W'(tbl[i].res), W'(tbl[i].thr));
      for (int n = 0; n < tbl[i].b_n; n++) cyc(0, 0, 1, cls_oh(tbl[i].b_cls), W'(tbl[i].res), W'(tbl[i].thr));
      cyc(0, 1, 0, '0, 0, 0);
      resolve_check($sformatf("tbl%0d", i), tbl[i].cls8, tbl[i].v8, tbl[i].cls4, tbl[i].v4, tbl[i].nd, 1'b0);
    end

    // Filtering and restart: vote on restart cycle dropped, zero/multi-hot dropped,
    // vote on the end cycle counted.
    cyc(1, 0, 0, '0, 0, 0);
    for (int n = 0; n < 3; n++) cyc(0, 0, 1, cls_oh(7), 10, 1);
    cyc(1, 0, 1, cls_oh(7), 10, 1);
    cyc(0, 0, 1, 10'd0, 10, 1);
    cyc(0, 0, 1, 10'b0000000011, 10, 1);
    cyc(0, 1, 1, cls_oh(4), 10, 1);
    resolve_check("filter_restart", 4, 1, 4, 1, 0, 1'b1);

    // start and end together in ACC: end wins, vote counted.
    cyc(1, 0, 0, '0, 0, 0);
    cyc(0, 0, 1, cls_oh(3), 9, 9);
    cyc(0, 0, 1, cls_oh(3), 9, 9);
    cyc(1, 1, 1, cls_oh(3), 9, 9);
    resolve_check("start_end_both", 3, 3, 3, 3, 0, 1'b0);

    // 8-bit counter saturation.
    cyc(1, 0, 0, '0, 0, 0);
    for (int n = 0; n < 260; n++) cyc(0, 0, 1, cls_oh(5), 1, 1);
    cyc(0, 1, 0, '0, 0, 0);
    resolve_check("sat8", 5, 255, 5, 15, 0, 1'b0);

    // Reset in the middle of the scan: no done, everything back to zero.
    cyc(1, 0, 0, '0, 0, 0);
    for (int n = 0; n < 4; n++) cyc(0, 0, 1, cls_oh(6), 2, 1);
    cyc(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    check_reset_state("rst_mid_resolve");
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_a || done_b || busy_a) seen = 1;
    end
    check("rst_mid_resolve/no_done_after", 32'(seen), 32'd0);
    cyc(1, 0, 0, '0, 0, 0);
    cyc(0, 0, 1, cls_oh(8), 2, 1);
    cyc(0, 0, 1, cls_oh(8), 2, 1);
    cyc(0, 1, 0, '0, 0, 0);
    resolve_check("after_reset", 8, 2, 8, 2, 0, 1'b0);

    // Randomized windows against the reference model.
    for (int w = 0; w < 30; w++) begin
      cyc(1, 0, 0, '0, 0, 0);
      nc = $urandom_range(1, 50);
      for (int n = 0; n < nc; n++) begin
        sel = $urandom_range(0, 9);
        if (sel < 7)       rix = cls_oh($urandom_range(0, 9));
        else if (sel == 7) rix = 10'd0;
        else               rix = 10'($urandom);
        cyc(($urandom_range(0, 40) == 0), 1'b0, 1'($urandom_range(0, 3) != 0), rix,
            W'($urandom_range(0, 20)), W'($urandom_range(0, 20)));
      end
      rix = cls_oh($urandom_range(0, 9));
      cyc(1'($urandom), 1'b1, 1'($urandom), rix, W'($urandom_range(0, 20)), W'($urandom_range(0, 20)));
      model_resolve($sformatf("rand%0d", w), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
